// File: rtl/btn_conditioner.sv
// btn_conditioner: input stage for the 3-button state machine.
// Each raw button line goes through a 2-flop synchroniser and then its own
// debounce FSM with a counter. Clean registered levels appear on b; b_changed
// pulses for one cycle whenever any bit of b changes.
// Optional build macro BTN_COND_EDGE_EN: when defined, b_rise/b_fall carry
// one-cycle per-channel edge pulses; when undefined they are tied to zero and
// no edge registers exist.
module btn_conditioner #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:1] btn_raw,
  output logic [3:1] b,
  output logic [3:1] b_rise,
  output logic [3:1] b_fall,
  output logic       b_changed
);

  // Per-channel debounce states. The current state of every channel is held
  // in state_q, which is the signal to probe when observing the FSMs.
  typedef enum logic [1:0] {
    IDLE_LO = 2'd0,
    CHK_HI  = 2'd1,
    IDLE_HI = 2'd2,
    CHK_LO  = 2'd3
  } state_t;

  // Last count value before a pending level is accepted.
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [3:1]       s1;
  logic [3:1]       s2;
  state_t           state_q [3:1];
  state_t           state_d [3:1];
  logic [CNT_W-1:0] cnt_q   [3:1];
  logic [CNT_W-1:0] cnt_d   [3:1];
  logic [3:1]       b_d;

  // Two-flop synchroniser per channel; only s2 feeds the debounce logic.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= btn_raw;
      s2 <= s1;
    end
  end

  // Next-state logic: a new level must be seen on DEBOUNCE_CYCLES+1
  // consecutive samples (entry cycle plus DEBOUNCE_CYCLES counted cycles).
  always_comb begin
    for (int i = 1; i <= 3; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      b_d[i]     = b[i];
      case (state_q[i])
        IDLE_LO: begin
          if (s2[i]) begin
            state_d[i] = CHK_HI;
            cnt_d[i]   = '0;
          end
        end
        CHK_HI: begin
          if (!s2[i]) begin
            state_d[i] = IDLE_LO;
          end else if (cnt_q[i] == CNT_MAX) begin
            state_d[i] = IDLE_HI;
            b_d[i]     = 1'b1;
          end else begin
            cnt_d[i] = cnt_q[i] + 1'b1;
          end
        end
        IDLE_HI: begin
          if (!s2[i]) begin
            state_d[i] = CHK_LO;
            cnt_d[i]   = '0;
          end
        end
        CHK_LO: begin
          if (s2[i]) begin
            state_d[i] = IDLE_HI;
          end else if (cnt_q[i] == CNT_MAX) begin
            state_d[i] = IDLE_LO;
            b_d[i]     = 1'b0;
          end else begin
            cnt_d[i] = cnt_q[i] + 1'b1;
          end
        end
        default: begin
          state_d[i] = IDLE_LO;
          cnt_d[i]   = '0;
        end
      endcase
    end
  end

  // State/counter registers; reset discards any debounce in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 1; i <= 3; i++) begin
        state_q[i] <= IDLE_LO;
        cnt_q[i]   <= '0;
      end
    end else begin
      for (int i = 1; i <= 3; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
    end
  end

  // Debounced level and the any-change pulse, registered together.
  always_ff @(posedge clk) begin
    if (rst) begin
      b         <= '0;
      b_changed <= 1'b0;
    end else begin
      b         <= b_d;
      b_changed <= |(b_d ^ b);
    end
  end

`ifdef BTN_COND_EDGE_EN
  // Per-channel edge pulses, aligned with the cycle b takes its new value.
  always_ff @(posedge clk) begin
    if (rst) begin
      b_rise <= '0;
      b_fall <= '0;
    end else begin
      b_rise <= b_d & ~b;
      b_fall <= ~b_d & b;
    end
  end
`else
  assign b_rise = '0;
  assign b_fall = '0;
`endif

endmodule

// File: tb/tb_btn_conditioner.sv
// Testbench for btn_conditioner (default DEBOUNCE_CYCLES=4). Works in both
// builds: expected b_rise/b_fall are masked off when BTN_COND_EDGE_EN is
// undefined.
module tb_btn_conditioner;

  localparam int D = 4;
`ifdef BTN_COND_EDGE_EN
  localparam logic [3:1] EMASK = 3'b111;
`else
  localparam logic [3:1] EMASK = 3'b000;
`endif

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:1] btn_raw = 3'b000;
  logic [3:1] b, b_rise, b_fall;
  logic       b_changed;

  always #5 clk = ~clk;

  btn_conditioner #(.DEBOUNCE_CYCLES(D)) dut (
    .clk      (clk),
    .rst      (rst),
    .btn_raw  (btn_raw),
    .b        (b),
    .b_rise   (b_rise),
    .b_fall   (b_fall),
    .b_changed(b_changed)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_err = 0;
  logic [9:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // A level is accepted once the last D+1 synchronised samples all show it.
  // The synchroniser is modelled as a two-deep delay that reset zeroes.
  logic [3:1] m_s1 = '0, m_s2 = '0, m_b = '0;
  logic [3:1] m_win[$];

  task automatic model_edge(input logic r, input logic [3:1] raw);
    logic [3:1] nb, rise, fall;
    logic       all_same;
    if (r) begin
      m_s1 = '0;
      m_s2 = '0;
      m_b  = '0;
      m_win.delete();
      rise = '0;
      fall = '0;
    end else begin
      m_win.push_back(m_s2);
      if (m_win.size() > D + 1) void'(m_win.pop_front());
      nb = m_b;
      if (m_win.size() == D + 1) begin
        for (int ch = 1; ch <= 3; ch++) begin
          all_same = 1'b1;
          foreach (m_win[k]) if (m_win[k][ch] != m_win[0][ch]) all_same = 1'b0;
          if (all_same && (m_win[0][ch] != m_b[ch])) nb[ch] = m_win[0][ch];
        end
      end
      rise = nb & ~m_b;
      fall = ~nb & m_b;
      m_s2 = m_s1;
      m_s1 = raw;
      exp_q.push_back({nb, rise & EMASK, fall & EMASK, |(nb ^ m_b)});
      m_b = nb;
      return;
    end
    exp_q.push_back({m_b, rise, fall, 1'b0});
  endtask

  // ---------------- driver ----------------
  // Inputs change on the falling edge; outputs are sampled 1 time unit after
  // the rising edge and compared against the model.
  task automatic step(input logic r, input logic [3:1] raw);
    logic [9:0] e;
    @(negedge clk);
    rst     = r;
    btn_raw = raw;
    @(posedge clk);
    model_edge(r, raw);
    #1;
    e = exp_q.pop_front();
    check("model", {b, b_rise, b_fall, b_changed}, e);
  endtask

  task automatic do_reset();
    step(1'b1, 3'b000);
    step(1'b1, 3'b000);
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic       r;
    logic [3:1] raw;
    logic [3:1] eb;
    logic [3:1] er;
    logic [3:1] ef;
    logic       ec;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input logic r, input logic [3:1] raw, input logic [3:1] eb,
                     input logic [3:1] er, input logic [3:1] ef, input logic ec);
    vec_t v;
    v.r = r; v.raw = raw; v.eb = eb; v.er = er; v.ef = ef; v.ec = ec;
    tbl.push_back(v);
  endtask

  // ---------------- test sequence ----------------
  logic [3:1] act_acc;
  logic       act_chg;
  int         rise_e, fall_e, fpulse_e;
  logic [3:1] cur;
  int         hold;

  initial begin
    // Reset then idle: nothing may ever assert.
    do_reset();
    check("reset_state", {b, b_rise, b_fall, b_changed}, 10'd0);
    act_acc = '0; act_chg = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 3'b000);
      act_acc = act_acc | b | b_rise | b_fall;
      act_chg = act_chg | b_changed;
    end
    check("idle_quiet", {act_acc, act_chg}, 4'd0);

    // Table: clean press/release on ch1, then simultaneous ch1+ch3.
    add(1, 3'b000, 3'b000, 3'b000, 3'b000, 0);
    add(1, 3'b000, 3'b000, 3'b000, 3'b000, 0);
    for (int e = 1; e <= 9; e++)
      if (e < 7)       add(0, 3'b001, 3'b000, 3'b000, 3'b000, 0);
      else if (e == 7) add(0, 3'b001, 3'b001, 3'b001, 3'b000, 1);
      else             add(0, 3'b001, 3'b001, 3'b000, 3'b000, 0);
    for (int e = 1; e <= 9; e++)
      if (e < 7)       add(0, 3'b000, 3'b001, 3'b000, 3'b000, 0);
      else if (e == 7) add(0, 3'b000, 3'b000, 3'b000, 3'b001, 1);
      else             add(0, 3'b000, 3'b000, 3'b000, 3'b000, 0);
    for (int e = 1; e <= 8; e++)
      if (e < 7)       add(0, 3'b101, 3'b000, 3'b000, 3'b000, 0);
      else if (e == 7) add(0, 3'b101, 3'b101, 3'b101, 3'b000, 1);
      else             add(0, 3'b101, 3'b101, 3'b000, 3'b000, 0);
    for (int e = 1; e <= 8; e++)
      if (e < 7)       add(0, 3'b000, 3'b101, 3'b000, 3'b000, 0);
      else if (e == 7) add(0, 3'b000, 3'b000, 3'b000, 3'b101, 1);
      else             add(0, 3'b000, 3'b000, 3'b000, 3'b000, 0);
    foreach (tbl[i]) begin
      step(tbl[i].r, tbl[i].raw);
      check($sformatf("table[%0d]", i), {b, b_rise, b_fall, b_changed},
            {tbl[i].eb, tbl[i].er & EMASK, tbl[i].ef & EMASK, tbl[i].ec});
    end

    // Glitch of exactly D clocks on ch2 is rejected.
    do_reset();
    act_acc = '0; act_chg = 1'b0;
    for (int e = 1; e <= 16; e++) begin
      step(1'b0, (e <= 4) ? 3'b010 : 3'b000);
      act_acc = act_acc | b | b_rise | b_fall;
      act_chg = act_chg | b_changed;
    end
    check("glitch4_quiet", {act_acc, act_chg}, 4'd0);

    // D+1 clocks is accepted: rise on edge 7, fall 7 edges after release.
    do_reset();
    rise_e = 0; fall_e = 0; fpulse_e = 0;
    for (int e = 1; e <= 25; e++) begin
      step(1'b0, (e <= 5) ? 3'b010 : 3'b000);
      if (b[2] && rise_e == 0) rise_e = e;
      if (rise_e != 0 && !b[2] && fall_e == 0) fall_e = e;
      if (b_fall == 3'b010 && fpulse_e == 0) fpulse_e = e;
    end
    check("glitch5_rise_edge", rise_e, 7);
    check("glitch5_fall_edge", fall_e, 12);
    check("glitch5_fall_pulse_edge", fpulse_e, (EMASK != 3'b000) ? 12 : 0);

    // Reset mid-debounce on ch3 at edge 5.
    do_reset();
    for (int e = 1; e <= 4; e++) step(1'b0, 3'b100);
    step(1'b1, 3'b100);
    check("midreset_b", b, 3'b000);
    rise_e = 0;
    for (int e = 1; e <= 20; e++) begin
      step(1'b0, 3'b100);
      if (b[3] && rise_e == 0) rise_e = e;
    end
    check("midreset_rise_edge", rise_e, 7);

    // Randomised segments against the model.
    do_reset();
    cur = 3'b000;
    for (int seg = 0; seg < 600; seg++) begin
      cur  = cur ^ 3'($urandom_range(0, 7));
      hold = $urandom_range(1, 8);
      for (int k = 0; k < hold; k++)
        step(($urandom_range(0, 199) == 0) ? 1'b1 : 1'b0, cur);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
